fwd_hazard_ctrl: RTL
====================

// Module: fwd_hazard_ctrl
// PURPOSE
//  Tracks destination registers of the two in-flight instructions (EX, MEM slots) and drives the
//  register file's forwarding controls: per-operand EX flag (2'b11 data ready, 2'b01 load pending,
//  2'b00 none), MEM flag, and EX/MEM forward data. Sits between id and regs. Owns load-use
//  stall sequencing (FSM + counter) and bubble injection on stall/flush.
// PARAMETERS
//  LOAD_LAT   1   stall cycles inserted on load-use hazard (1..7)
//  CNT_W      32  width of statistics counters (FWD_STATS_EN only)
// PORTS
//  clk                     in   1   core clock
//  rst                     in   1   asynchronous reset, active-low
//  id_valid_i              in   1   ID holds a valid instruction
//  raddr1_i / raddr2_i     in   5   ID source register addresses
//  re1_i / re2_i           in   1   ID actually reads rs1 / rs2
//  id_waddr_i              in   5   ID destination register
//  id_we_i                 in   1   ID instruction writes rd
//  id_is_load_i            in   1   ID instruction is a load
//  ex_wdata_i              in   32  EX-stage ALU result (combinational, current cycle)
//  mem_rdata_i             in   32  load data returned in MEM stage
//  hold_i                  in   1   pipeline hold from ctrl: freeze all state
//  flush_i                 in   1   jump/trap flush: squash EX slot, abort stall
//  reg1_exforward_flag_o   out  2   EX forward code, operand 1
//  reg2_exforward_flag_o   out  2   EX forward code, operand 2
//  reg1_memforward_flag_o  out  1   MEM forward select, operand 1
//  reg2_memforward_flag_o  out  1   MEM forward select, operand 2
//  ex_wdata_tem_o          out  32  EX forward data
//  mem_wdata_tem_o         out  32  MEM forward data
//  stall_o                 out  1   load-use stall request to ctrl (hold PC/IF/ID)
//  fwd_cnt_o / stall_cnt_o out  CNT_W statistics (FWD_STATS_EN)
// BEHAVIOUR
//  - Slots: EX{v,rd,we,ld}, MEM{v,rd,we,ld,data}. Reset: all v=0, data=0, FSM IDLE, cnt=0.
//  - Advance each clk when !hold_i: MEM<=EX (data<=ex_wdata_i); EX<=ID if id_valid_i & !stall_o
//    & !flush_i, else bubble (v=0). hold_i has priority over all except rst.
//  - Match(slot,a): slot.v & slot.we & slot.rd!=0 & slot.rd==a. x0 never matches.
//  - EX flag (comb): Match(EX,raddrN) & reN ? (EX.ld ? 2'b01 : 2'b11) : 2'b00.
//  - MEM flag (comb): Match(MEM,raddrN) & reN & no EX match on that operand (EX younger wins).
//  - ex_wdata_tem_o = ex_wdata_i; mem_wdata_tem_o = MEM.ld ? mem_rdata_i : MEM.data.
//  - Outputs are combinational from slots/inputs; all 0 while rst low.
//  - FSM IDLE: hazard = any EX flag==2'b01 & id_valid_i. hazard & !flush_i -> stall_o=1,
//    bubble into EX, cnt<=LOAD_LAT-1, go WAIT (LOAD_LAT=1: WAIT skipped, back to IDLE).
//  - FSM WAIT: stall_o=1, bubble into EX, cnt--; cnt==0 -> IDLE. Load has then reached MEM,
//    so the next ID cycle resolves via MEM flag (load data via mem_rdata_i).
//  - flush_i in any state: EX<=bubble, FSM->IDLE, stall_o=0 same cycle; MEM still advances.
//  - hold_i in WAIT: cnt and state frozen; stall_o stays 1.
//  - rst asserted mid-stall: immediate return to IDLE, slots cleared, stall_o=0.
//  - Back-to-back loads feeding each other stall once per dependency; non-dependent load: no stall.
// CONFIGURATION
//  FWD_STATS_EN defined: fwd_cnt_o increments once per advancing cycle with any flag 2'b11 or
//   MEM flag set; stall_cnt_o increments each cycle stall_o=1 & !hold_i; both saturate at all-ones,
//   reset to 0. Undefined: counters not built, fwd_cnt_o/stall_cnt_o tied to 0.
// TESTING
//  add x5 in EX, ID reads x5 via rs1 -> reg1_exforward_flag_o=2'b11, ex_wdata_tem_o=ex_wdata_i.
//  add x5 two ahead, ID reads x5 via rs2 -> reg2_memforward_flag_o=1, mem_wdata_tem_o=stored result.
//  lw x7 in EX, ID add uses x7 -> flag 2'b01, stall_o=1 for LOAD_LAT cycles, then MEM flag=1,
//   mem_wdata_tem_o=mem_rdata_i=32'hDEADBEEF.
//  EX and MEM both write x3, ID reads x3 -> EX flag 2'b11, MEM flag 0; rd=x0 writes -> all flags 0.
//  flush_i during load-use stall -> stall_o drops same cycle, EX slot bubble, FSM IDLE.
//  FWD_STATS_EN: 3 EX forwards + 1 load-use stall (LOAD_LAT=2) -> fwd_cnt_o=3, stall_cnt_o=2.

Source files
------------

// File: rtl/fwd_hazard_ctrl_if.sv
// Bus between the ID stage / register file and the forwarding + load-use hazard controller.
interface fwd_hazard_ctrl_if #(
   parameter int CNT_W = 32
);
   logic             id_valid_i;
   logic [4:0]       raddr1_i;
   logic [4:0]       raddr2_i;
   logic             re1_i;
   logic             re2_i;
   logic [4:0]       id_waddr_i;
   logic             id_we_i;
   logic             id_is_load_i;
   logic [31:0]      ex_wdata_i;
   logic [31:0]      mem_rdata_i;
   logic             hold_i;
   logic             flush_i;
   logic [1:0]       reg1_exforward_flag_o;
   logic [1:0]       reg2_exforward_flag_o;
   logic             reg1_memforward_flag_o;
   logic             reg2_memforward_flag_o;
   logic [31:0]      ex_wdata_tem_o;
   logic [31:0]      mem_wdata_tem_o;
   logic             stall_o;
   logic [CNT_W-1:0] fwd_cnt_o;
   logic [CNT_W-1:0] stall_cnt_o;

   modport master (
      output id_valid_i, raddr1_i, raddr2_i, re1_i, re2_i, id_waddr_i, id_we_i,
             id_is_load_i, ex_wdata_i, mem_rdata_i, hold_i, flush_i,
      input  reg1_exforward_flag_o, reg2_exforward_flag_o, reg1_memforward_flag_o,
             reg2_memforward_flag_o, ex_wdata_tem_o, mem_wdata_tem_o, stall_o,
             fwd_cnt_o, stall_cnt_o
   );

   modport slave (
      input  id_valid_i, raddr1_i, raddr2_i, re1_i, re2_i, id_waddr_i, id_we_i,
             id_is_load_i, ex_wdata_i, mem_rdata_i, hold_i, flush_i,
      output reg1_exforward_flag_o, reg2_exforward_flag_o, reg1_memforward_flag_o,
             reg2_memforward_flag_o, ex_wdata_tem_o, mem_wdata_tem_o, stall_o,
             fwd_cnt_o, stall_cnt_o
   );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// EX/MEM destination tracking, operand forwarding controls and load-use stall sequencing.
// Optional statistics counters are built when FWD_STATS_EN is defined.
module fwd_hazard_ctrl #(
   parameter int LOAD_LAT = 1,
   parameter int CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst,
   fwd_hazard_ctrl_if.slave bus
);

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   localparam logic [2:0] LAT_M1   = 3'(LOAD_LAT - 1);
   localparam bit         HAS_WAIT = (LOAD_LAT > 1);

   logic        r_ex_v, r_ex_we, r_ex_ld;
   logic [4:0]  r_ex_rd;
   logic        r_mem_v, r_mem_we, r_mem_ld;
   logic [4:0]  r_mem_rd;
   logic [31:0] r_mem_data;

   state_t      r_state, w_state_nxt;
   logic [2:0]  r_cnt, w_cnt_nxt;
   logic        w_stall;

   logic        w_ex_m1, w_ex_m2, w_mem_m1, w_mem_m2, w_hazard;
   logic [1:0]  w_ex_f1, w_ex_f2;

   // x0 is hardwired zero, so a write to it is never a forwarding source
   function automatic logic slot_match(input logic v, input logic we,
                                       input logic [4:0] rd, input logic [4:0] a);
      return v && we && (rd != 5'd0) && (rd == a);
   endfunction

   assign w_ex_m1  = slot_match(r_ex_v, r_ex_we, r_ex_rd, bus.raddr1_i) && bus.re1_i;
   assign w_ex_m2  = slot_match(r_ex_v, r_ex_we, r_ex_rd, bus.raddr2_i) && bus.re2_i;
   assign w_mem_m1 = slot_match(r_mem_v, r_mem_we, r_mem_rd, bus.raddr1_i) && bus.re1_i && !w_ex_m1;
   assign w_mem_m2 = slot_match(r_mem_v, r_mem_we, r_mem_rd, bus.raddr2_i) && bus.re2_i && !w_ex_m2;
   assign w_ex_f1  = w_ex_m1 ? (r_ex_ld ? 2'b01 : 2'b11) : 2'b00;
   assign w_ex_f2  = w_ex_m2 ? (r_ex_ld ? 2'b01 : 2'b11) : 2'b00;
   assign w_hazard = bus.id_valid_i && ((w_ex_f1 == 2'b01) || (w_ex_f2 == 2'b01));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ex_v     <= 1'b0;
         r_ex_we    <= 1'b0;
         r_ex_ld    <= 1'b0;
         r_ex_rd    <= 5'd0;
         r_mem_v    <= 1'b0;
         r_mem_we   <= 1'b0;
         r_mem_ld   <= 1'b0;
         r_mem_rd   <= 5'd0;
         r_mem_data <= 32'd0;
      end else if (!bus.hold_i) begin
         r_mem_v    <= r_ex_v;
         r_mem_we   <= r_ex_we;
         r_mem_ld   <= r_ex_ld;
         r_mem_rd   <= r_ex_rd;
         r_mem_data <= bus.ex_wdata_i;
         if (bus.id_valid_i && !w_stall && !bus.flush_i) begin
            r_ex_v  <= 1'b1;
            r_ex_we <= bus.id_we_i;
            r_ex_ld <= bus.id_is_load_i;
            r_ex_rd <= bus.id_waddr_i;
         end else begin
            r_ex_v  <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_cnt   <= 3'd0;
      end else if (!bus.hold_i) begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // The detect cycle in IDLE is the first stall cycle; WAIT supplies the remaining LOAD_LAT-1
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      if (bus.flush_i) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: if (w_hazard) begin
               w_cnt_nxt   = LAT_M1;
               w_state_nxt = HAS_WAIT ? S_WAIT : S_IDLE;
            end
            S_WAIT: begin
               w_cnt_nxt = r_cnt - 3'd1;
               if (r_cnt <= 3'd1) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_comb begin
      w_stall = 1'b0;
      if (!bus.flush_i) begin
         case (r_state)
            S_IDLE:  w_stall = w_hazard;
            S_WAIT:  w_stall = 1'b1;
            default: w_stall = 1'b0;
         endcase
      end
   end

   assign bus.reg1_exforward_flag_o  = rst ? w_ex_f1 : 2'b00;
   assign bus.reg2_exforward_flag_o  = rst ? w_ex_f2 : 2'b00;
   assign bus.reg1_memforward_flag_o = rst && w_mem_m1;
   assign bus.reg2_memforward_flag_o = rst && w_mem_m2;
   assign bus.ex_wdata_tem_o         = rst ? bus.ex_wdata_i : 32'd0;
   assign bus.mem_wdata_tem_o        = !rst ? 32'd0 : (r_mem_ld ? bus.mem_rdata_i : r_mem_data);
   assign bus.stall_o                = rst && w_stall;

`ifdef FWD_STATS_EN
   logic [CNT_W-1:0] r_fwd_cnt, r_stall_cnt;
   logic             w_fwd_any;

   assign w_fwd_any = (w_ex_f1 == 2'b11) || (w_ex_f2 == 2'b11) || w_mem_m1 || w_mem_m2;

   // Both counters saturate instead of wrapping
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_fwd_cnt   <= '0;
         r_stall_cnt <= '0;
      end else if (!bus.hold_i) begin
         if (w_fwd_any && !(&r_fwd_cnt))   r_fwd_cnt   <= r_fwd_cnt + CNT_W'(1);
         if (w_stall && !(&r_stall_cnt))   r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
   end

   assign bus.fwd_cnt_o   = r_fwd_cnt;
   assign bus.stall_cnt_o = r_stall_cnt;
`else
   assign bus.fwd_cnt_o   = '0;
   assign bus.stall_cnt_o = '0;
`endif

endmodule
